alu_issue_stage: RTL and testbench

- Registered decode/issue stage of the pipelined RV32I core. Sits between register read and the ALU.
- Accepts one instruction per beat, together with its PC and both register-file read values.
- Produces the team-standard 4-bit ALU control code plus fully resolved ALU operands A/B, held in an output register with valid/ready handshake.
- Supports backpressure, pipeline flush and illegal-instruction flagging.

---
 rtl/alu_issue_stage.sv | 210 +++++++++++++++++++++
 tb/tb_alu_issue_stage.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/alu_issue_stage.sv
// RV32I decode/issue stage: resolves ALU control and operands from a
// register-read beat and holds them in a valid/ready output register.
module alu_issue_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   input  logic [XLEN-1:0] in_pc,
   input  logic [XLEN-1:0] in_rs1_data,
   input  logic [XLEN-1:0] in_rs2_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [3:0]      out_alu_ctrl,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   localparam logic [3:0] ALU_ADD  = 4'b0000;
   localparam logic [3:0] ALU_SUB  = 4'b0001;
   localparam logic [3:0] ALU_AND  = 4'b0010;
   localparam logic [3:0] ALU_OR   = 4'b0011;
   localparam logic [3:0] ALU_XOR  = 4'b0100;
   localparam logic [3:0] ALU_SLT  = 4'b0101;
   localparam logic [3:0] ALU_SRA  = 4'b0110;
   localparam logic [3:0] ALU_SRL  = 4'b0111;
   localparam logic [3:0] ALU_SLL  = 4'b1000;
   localparam logic [3:0] ALU_SLTU = 4'b1001;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   logic [6:0]      opc;
   logic [2:0]      f3;
   logic [6:0]      f7;
   logic [XLEN-1:0] i_imm;
   logic [XLEN-1:0] s_imm;
   logic [XLEN-1:0] u_imm;
   logic [XLEN-1:0] shamt;
   logic [3:0]      f3_ctrl;

   logic [3:0]      ctrl_d, ctrl_q;
   logic [XLEN-1:0] a_d, a_q;
   logic [XLEN-1:0] b_d, b_q;
   logic [4:0]      rd_q;
   logic            ill_d, ill_q;
   logic            valid_d, valid_q;
   logic            accept;
   logic            unused_rs1_addr;

   assign opc   = in_instr[6:0];
   assign f3    = in_instr[14:12];
   assign f7    = in_instr[31:25];
   assign i_imm = {{20{in_instr[31]}}, in_instr[31:20]};
   assign s_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
   assign u_imm = {in_instr[31:12], 12'b0};
   assign shamt = {27'b0, in_instr[24:20]};
   assign unused_rs1_addr = ^in_instr[19:15];

   // Base funct3 map shared by OP and OP-IMM; SUB/SRA resolved by funct7.
   always_comb begin
      f3_ctrl = ALU_ADD;
      unique case (f3)
         3'b000: f3_ctrl = ALU_ADD;
         3'b001: f3_ctrl = ALU_SLL;
         3'b010: f3_ctrl = ALU_SLT;
         3'b011: f3_ctrl = ALU_SLTU;
         3'b100: f3_ctrl = ALU_XOR;
         3'b101: f3_ctrl = ALU_SRL;
         3'b110: f3_ctrl = ALU_OR;
         3'b111: f3_ctrl = ALU_AND;
         default: f3_ctrl = ALU_ADD;
      endcase
   end

   always_comb begin
      ctrl_d = ALU_ADD;
      a_d    = '0;
      b_d    = '0;
      ill_d  = 1'b0;
      unique case (opc)
         OPC_OP: begin
            a_d = in_rs1_data;
            b_d = in_rs2_data;
            if (f7 == F7_BASE)
               ctrl_d = f3_ctrl;
            else if (f7 == F7_ALT && f3 == 3'b000)
               ctrl_d = ALU_SUB;
            else if (f7 == F7_ALT && f3 == 3'b101)
               ctrl_d = ALU_SRA;
            else
               ill_d = 1'b1;
         end
         OPC_OPIMM: begin
            a_d    = in_rs1_data;
            b_d    = i_imm;
            ctrl_d = f3_ctrl;
            if (f3 == 3'b001) begin
               b_d = shamt;
               if (f7 != F7_BASE)
                  ill_d = 1'b1;
            end else if (f3 == 3'b101) begin
               b_d = shamt;
               if (f7 == F7_ALT)
                  ctrl_d = ALU_SRA;
               else if (f7 != F7_BASE)
                  ill_d = 1'b1;
            end
         end
         OPC_LUI: begin
            b_d = u_imm;
         end
         OPC_AUIPC: begin
            a_d = in_pc;
            b_d = u_imm;
         end
         OPC_JAL: begin
            a_d = in_pc;
            b_d = 32'd4;
         end
         OPC_JALR: begin
            a_d = in_pc;
            b_d = 32'd4;
            if (f3 != 3'b000)
               ill_d = 1'b1;
         end
         OPC_LOAD: begin
            a_d = in_rs1_data;
            b_d = i_imm;
         end
         OPC_STORE: begin
            a_d = in_rs1_data;
            b_d = s_imm;
         end
         OPC_BRANCH: begin
            a_d = in_rs1_data;
            b_d = in_rs2_data;
            unique case (f3[2:1])
               2'b00: ctrl_d = ALU_SUB;
               2'b10: ctrl_d = ALU_SLT;
               2'b11: ctrl_d = ALU_SLTU;
               default: ill_d = 1'b1;
            endcase
         end
         default: ill_d = 1'b1;
      endcase
      // Illegal beats carry a canonical zeroed payload.
      if (ill_d) begin
         ctrl_d = ALU_ADD;
         a_d    = '0;
         b_d    = '0;
      end
   end

   assign in_ready = !valid_q || out_ready;
   assign accept   = in_valid && in_ready && !flush;

   always_comb begin
      valid_d = valid_q;
      if (flush)
         valid_d = 1'b0;
      else if (accept)
         valid_d = 1'b1;
      else if (out_ready)
         valid_d = 1'b0;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_q <= 1'b0;
         ctrl_q  <= ALU_ADD;
         a_q     <= '0;
         b_q     <= '0;
         rd_q    <= '0;
         ill_q   <= 1'b0;
      end else begin
         valid_q <= valid_d;
         if (accept) begin
            ctrl_q <= ctrl_d;
            a_q    <= a_d;
            b_q    <= b_d;
            rd_q   <= in_instr[11:7];
            ill_q  <= ill_d;
         end
      end
   end

   assign out_valid    = valid_q;
   assign out_alu_ctrl = ctrl_q;
   assign out_a        = a_q;
   assign out_b        = b_q;
   assign out_rd       = rd_q;
   assign out_illegal  = ill_q;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed bench for alu_issue_stage: decode table, backpressure,
// flush and asynchronous reset.
module tb_alu_issue_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [31:0] in_pc;
   logic [31:0] in_rs1_data;
   logic [31:0] in_rs2_data;
   logic        flush;
   logic        out_valid;
   logic        out_ready;
   logic [3:0]  out_alu_ctrl;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [4:0]  out_rd;
   logic        out_illegal;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   alu_issue_stage dut (
      .clk          (clk),
      .rst          (rst),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_instr     (in_instr),
      .in_pc        (in_pc),
      .in_rs1_data  (in_rs1_data),
      .in_rs2_data  (in_rs2_data),
      .flush        (flush),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_alu_ctrl (out_alu_ctrl),
      .out_a        (out_a),
      .out_b        (out_b),
      .out_rd       (out_rd),
      .out_illegal  (out_illegal)
   );

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      n_chk++;
      if (obs === exp)
         n_pass++;
      else
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
   endtask

   typedef struct {
      logic [31:0] instr;
      logic [3:0]  ctrl;
      logic [31:0] a;
      logic [31:0] b;
      logic        ill;
      logic [4:0]  rd;
   } vec_t;

   // pc=0x100, rs1=5, rs2=3 for every row
   vec_t vecs[21] = '{
      '{32'h402081B3, 4'h1, 32'h5,   32'h3,        1'b0, 5'd3},
      '{32'hFFF00093, 4'h0, 32'h5,   32'hFFFFFFFF, 1'b0, 5'd1},
      '{32'h40415093, 4'h6, 32'h5,   32'h4,        1'b0, 5'd1},
      '{32'h123452B7, 4'h0, 32'h0,   32'h12345000, 1'b0, 5'd5},
      '{32'h12345297, 4'h0, 32'h100, 32'h12345000, 1'b0, 5'd5},
      '{32'h0000000B, 4'h0, 32'h0,   32'h0,        1'b1, 5'd0},
      '{32'h02208133, 4'h0, 32'h0,   32'h0,        1'b1, 5'd2},
      '{32'h00208063, 4'h1, 32'h5,   32'h3,        1'b0, 5'd0},
      '{32'h0020E063, 4'h9, 32'h5,   32'h3,        1'b0, 5'd0},
      '{32'h0020A063, 4'h0, 32'h0,   32'h0,        1'b1, 5'd0},
      '{32'h0020A423, 4'h0, 32'h5,   32'h8,        1'b0, 5'd8},
      '{32'hFFC12083, 4'h0, 32'h5,   32'hFFFFFFFC, 1'b0, 5'd1},
      '{32'h008000EF, 4'h0, 32'h100, 32'h4,        1'b0, 5'd1},
      '{32'h000090E7, 4'h0, 32'h0,   32'h0,        1'b1, 5'd1},
      '{32'h40109093, 4'h0, 32'h0,   32'h0,        1'b1, 5'd1},
      '{32'h0020B1B3, 4'h9, 32'h5,   32'h3,        1'b0, 5'd3},
      '{32'h0020E1B3, 4'h3, 32'h5,   32'h3,        1'b0, 5'd3},
      '{32'h000080E7, 4'h0, 32'h100, 32'h4,        1'b0, 5'd1},
      '{32'h00415093, 4'h7, 32'h5,   32'h4,        1'b0, 5'd1},
      '{32'h402051B3, 4'h6, 32'h5,   32'h3,        1'b0, 5'd3},
      '{32'h8000A093, 4'h5, 32'h5,   32'hFFFFF800, 1'b0, 5'd1}
   };

   task automatic chk_out(input string tag, input vec_t v);
      chk({tag, ".valid"}, {31'b0, out_valid}, 32'd1);
      chk({tag, ".ctrl"}, {28'b0, out_alu_ctrl}, {28'b0, v.ctrl});
      chk({tag, ".a"}, out_a, v.a);
      chk({tag, ".b"}, out_b, v.b);
      chk({tag, ".ill"}, {31'b0, out_illegal}, {31'b0, v.ill});
      chk({tag, ".rd"}, {27'b0, out_rd}, {27'b0, v.rd});
   endtask

   initial begin
      rst         = 1'b1;
      in_valid    = 1'b0;
      in_instr    = '0;
      in_pc       = 32'h100;
      in_rs1_data = 32'd5;
      in_rs2_data = 32'd3;
      flush       = 1'b0;
      out_ready   = 1'b1;
      #12;
      chk("rst.valid", {31'b0, out_valid}, 32'd0);
      chk("rst.ctrl", {28'b0, out_alu_ctrl}, 32'd0);
      chk("rst.a", out_a, 32'd0);
      chk("rst.b", out_b, 32'd0);
      chk("rst.ill", {31'b0, out_illegal}, 32'd0);
      chk("rst.in_ready", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      rst = 1'b0;

      // back-to-back stream through the decode table
      for (int i = 0; i < 21; i++) begin
         in_valid = 1'b1;
         in_instr = vecs[i].instr;
         @(negedge clk);
         chk_out($sformatf("vec%0d", i), vecs[i]);
      end
      in_valid = 1'b0;
      @(negedge clk);
      chk("drain.valid", {31'b0, out_valid}, 32'd0);

      // backpressure: SUB held while OR waits
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = vecs[0].instr;
      @(negedge clk);
      in_instr = vecs[16].instr;
      for (int c = 0; c < 3; c++) begin
         chk($sformatf("bp%0d.in_ready", c), {31'b0, in_ready}, 32'd0);
         chk_out($sformatf("bp%0d", c), vecs[0]);
         @(negedge clk);
      end
      out_ready = 1'b1;
      #1;
      chk("bp.in_ready_up", {31'b0, in_ready}, 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      chk_out("bp.next", vecs[16]);
      @(negedge clk);
      chk("bp.drain", {31'b0, out_valid}, 32'd0);

      // flush with a held beat and a new beat presented
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_instr  = vecs[0].instr;
      @(negedge clk);
      chk("fl.pre", {31'b0, out_valid}, 32'd1);
      in_instr = vecs[2].instr;
      flush    = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("fl.valid", {31'b0, out_valid}, 32'd0);

      // async reset during a stall
      @(negedge clk);
      in_valid = 1'b0;
      chk("ar.pre", {31'b0, out_valid}, 32'd1);
      #2 rst = 1'b1;
      #1;
      chk("ar.valid", {31'b0, out_valid}, 32'd0);
      chk("ar.ctrl", {28'b0, out_alu_ctrl}, 32'd0);
      chk("ar.a", out_a, 32'd0);
      chk("ar.b", out_b, 32'd0);
      chk("ar.rd", {27'b0, out_rd}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
